writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the single-issue MIPS core. It takes one retiring instruction per cycle from the MEM stage, waits for the data-memory response when the instruction is a load, and extracts and merges the load data. It presents a registered write port to the register file; that file's same-cycle bypass gives the value to ID readers in the cycle it is written. A three-state FSM handles variable-latency memory responses and flushes that land while a load is outstanding.

## Interface
Parameters: none. Widths come from `REG_DATA_WIDTH` and the shared types.
- clk  in  1  core clock
- rst  in  1  reset; synchronous and active-high; one clock
- mem_valid  in  1  MEM presents an instruction this cycle
- wb_ready  out  1  stage accepts an instruction (MEM holds while low)
- mem_wp  in  regWritePort_t  we/waddr/wdata; wdata is the ALU result for non-loads
- mem_is_load  in  1  instruction is a load
- mem_load_op  in  load_op_t  LB, LBU, LH, LHU, LW, LWL, LWR
- mem_addr_lo  in  2  effective address bits [1:0]
- mem_rt_old  in  word_t  current rt value, used for the LWL/LWR merge
- dresp_valid  in  1  data-memory read data valid, one-cycle pulse per load
- dresp_rdata  in  word_t  aligned word read from memory
- flush  in  1  kill the in-flight or presented instruction (exception/eret)
- wp_out  out  regWritePort_t  registered write port to the register file

## Operation
- States:
  - IDLE: nothing outstanding.
  - WAIT: captured load awaiting dresp.
  - DRAIN: flushed load whose response must still be consumed.
- wb_ready = (state == IDLE). It is combinational from state only.
- Accept = mem_valid & wb_ready & ~flush. If flush is high in the accept cycle, the input is dropped, wp_out.we = 0 next cycle, and state stays IDLE.
- IDLE behaviour on accept:
  - Non-load: wp_out <= mem_wp; state stays IDLE.
  - Load with dresp_valid in the same cycle: wp_out <= {mem_wp.we, waddr, extract(dresp_rdata)}; state stays IDLE.
  - Load without dresp_valid: capture waddr, we, op, addr_lo and rt_old; wp_out.we <= 0; go to WAIT.
- WAIT behaviour:
  - dresp_valid & ~flush: wp_out <= {captured we, captured waddr, extract}; go to IDLE.
  - flush & dresp_valid: discard the data; go to IDLE.
  - flush & ~dresp_valid: go to DRAIN.
  - Otherwise: wp_out.we <= 0; remain in WAIT.
- DRAIN: on dresp_valid go to IDLE with no write. flush is ignored in this state.
- Any cycle that does not load wp_out drives wp_out.we <= 0; waddr and wdata are don't-care.
- Writes to $0 are suppressed: wp_out.we is forced 0 when waddr == 0.
- extract, little-endian, with b = addr_lo, byte k = rdata[8k+7:8k]:
  - LB / LBU: byte b, sign-extended / zero-extended.
  - LH / LHU: halfword b[1], sign-extended / zero-extended. b[0] is not checked; misaligned accesses are trapped upstream.
  - LW: rdata.
  - LWL: ({rdata} << 8·(3−b)) | (rt_old & (32'hFFFFFF >> 8·b)). b = 3 gives rdata; b = 0 gives {rdata[7:0], rt_old[23:0]}.
  - LWR: ({rdata} >> 8·b) | (rt_old & ~(32'hFFFFFFFF >> 8·b)). b = 0 gives rdata; b = 3 gives {rt_old[31:8], rdata[31:24]}.
- dresp_valid in IDLE with no load being accepted is a protocol error. It is ignored; simulation asserts on it.

## Timing
- Reset:
  - state = IDLE.
  - wp_out = '0 (we = 0, waddr = 0, wdata = 0).
  - All captured fields are 0.
  - wb_ready = 1 in the cycle after reset.
- Latency:
  - Non-load: 1 cycle from accept to wp_out.we.
  - Load: 1 cycle after the dresp_valid cycle.
- wp_out.we is high for exactly one cycle per retired instruction.
- Throughput: 1 instruction per cycle when there are no load waits.
- wb_ready is low from the cycle after a waiting load is accepted until the cycle after its dresp_valid. The next instruction can be accepted in the same cycle that wp_out shows the load result.
- Reset mid-WAIT or mid-DRAIN returns to IDLE. Memory is reset in the same cycle, so no response is owed.

## Structure
- Add to the shared defines package:
  - load_op_t enum
  - wb_state_t enum {WB_IDLE, WB_WAIT, WB_DRAIN}
- regWritePort_t, word_t and regaddr_t are reused unchanged.
- One sub-module: load_extract. It is purely combinational: (op, addr_lo, rdata, rt_old) → word_t. It is instantiated once, fed by muxing the live inputs in IDLE and the captured fields in WAIT.

## Test plan
- Non-load: mem_wp = {1, 5, 32'h1234_5678} → next cycle wp_out = {1, 5, 32'h1234_5678}, then we = 0.
- LB, addr_lo = 2, rdata = 32'h00_80_00_00, same-cycle dresp → wdata = 32'hFFFF_FF80. LBU with the same inputs → 32'h0000_0080.
- LW with dresp 3 cycles after accept, rdata = 32'hCAFE_BABE:
  - wb_ready low for 3 cycles.
  - wp_out written once, the cycle after dresp.
  - A queued non-load is accepted that same cycle and written the next cycle.
- LWL b = 1, rt_old = 32'h1122_3344, rdata = 32'hAABB_CCDD → 32'hCCDD_3344. LWR b = 1 with the same inputs → 32'h11AA_BBCC.
- Flush in WAIT, dresp 2 cycles later:
  - State goes to DRAIN; no write occurs.
  - wb_ready stays low until the cycle after dresp, then returns high.
- Write to $0 (non-load and load) → wp_out.we = 0. Assert rst while in WAIT → next cycle wp_out = '0 and wb_ready = 1.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared core types plus writeback load ops and FSM states
package writeback_stage_pkg;
  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  typedef logic [REG_DATA_WIDTH-1:0] word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] regaddr_t;
  typedef struct packed {
    logic     we;
    regaddr_t waddr;
    word_t    wdata;
  } regWritePort_t;
  typedef enum logic [2:0] {LB, LBU, LH, LHU, LW, LWL, LWR} load_op_t;
  typedef enum logic [1:0] {WB_IDLE, WB_WAIT, WB_DRAIN} wb_state_t;
endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: MEM-to-writeback handshake, data response and register write port
interface writeback_stage_if;
  import writeback_stage_pkg::*;
  logic          mem_valid;
  logic          wb_ready;
  regWritePort_t mem_wp;
  logic          mem_is_load;
  load_op_t      mem_load_op;
  logic [1:0]    mem_addr_lo;
  word_t         mem_rt_old;
  logic          dresp_valid;
  word_t         dresp_rdata;
  logic          flush;
  regWritePort_t wp_out;
  modport master (
    output mem_valid, mem_wp, mem_is_load, mem_load_op, mem_addr_lo, mem_rt_old,
           dresp_valid, dresp_rdata, flush,
    input  wb_ready, wp_out
  );
  modport slave (
    input  mem_valid, mem_wp, mem_is_load, mem_load_op, mem_addr_lo, mem_rt_old,
           dresp_valid, dresp_rdata, flush,
    output wb_ready, wp_out
  );
endinterface

// File: rtl/writeback_stage_extract.sv
// load_extract: little-endian load data extraction and LWL/LWR merge
module load_extract
  import writeback_stage_pkg::*;
(
  input  load_op_t   op,
  input  logic [1:0] addr_lo,
  input  word_t      rdata,
  input  word_t      rt_old,
  output word_t      data
);
  logic [4:0]  sh;
  logic [7:0]  b8;
  logic [15:0] h16;
  assign sh  = {addr_lo, 3'b000};
  assign b8  = rdata[sh +: 8];
  assign h16 = rdata[{addr_lo[1], 4'b0000} +: 16];
  // ~addr_lo equals 3 - addr_lo for the LWL left shift
  always_comb begin
    case (op)
      LB:      data = {{24{b8[7]}}, b8};
      LBU:     data = {24'h0, b8};
      LH:      data = {{16{h16[15]}}, h16};
      LHU:     data = {16'h0, h16};
      LWL:     data = (rdata << {~addr_lo, 3'b000}) | (rt_old & (32'h00FF_FFFF >> sh));
      LWR:     data = (rdata >> sh) | (rt_old & ~(32'hFFFF_FFFF >> sh));
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: retires one instruction per cycle, waiting on and merging load data
module writeback_stage
  import writeback_stage_pkg::*;
(
  input logic              clk,
  input logic              rst,
  writeback_stage_if.slave bus
);
  wb_state_t     state, state_n;
  logic          idle, accept, start_wait, wr;
  logic          cap_we;
  regaddr_t      cap_waddr;
  load_op_t      cap_op, ext_op;
  logic [1:0]    cap_lo, ext_lo;
  word_t         cap_rt, ext_rt, ext;
  regWritePort_t wp_n;
  assign idle       = state == WB_IDLE;
  assign accept     = bus.mem_valid & idle & ~bus.flush;
  assign start_wait = accept & bus.mem_is_load & ~bus.dresp_valid;
  // the single extractor sees live inputs in IDLE and the captured load otherwise
  assign ext_op = idle ? bus.mem_load_op : cap_op;
  assign ext_lo = idle ? bus.mem_addr_lo : cap_lo;
  assign ext_rt = idle ? bus.mem_rt_old : cap_rt;
  load_extract u_extract (
    .op     (ext_op),
    .addr_lo(ext_lo),
    .rdata  (bus.dresp_rdata),
    .rt_old (ext_rt),
    .data   (ext)
  );
  always_ff @(posedge clk) state <= rst ? WB_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      WB_IDLE:  state_n = start_wait ? WB_WAIT : WB_IDLE;
      WB_WAIT:  state_n = bus.dresp_valid ? WB_IDLE : bus.flush ? WB_DRAIN : WB_WAIT;
      WB_DRAIN: state_n = bus.dresp_valid ? WB_IDLE : WB_DRAIN;
      default:  state_n = WB_IDLE;
    endcase
  end
  always_comb begin
    bus.wb_ready = idle;
    wr = idle ? accept & (~bus.mem_is_load | bus.dresp_valid)
              : (state == WB_WAIT) & bus.dresp_valid & ~bus.flush;
    wp_n.waddr = idle ? bus.mem_wp.waddr : cap_waddr;
    wp_n.wdata = idle & ~bus.mem_is_load ? bus.mem_wp.wdata : ext;
    wp_n.we    = wr & (idle ? bus.mem_wp.we : cap_we) & (wp_n.waddr != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wp_out <= '0;
      cap_we     <= 1'b0;
      cap_waddr  <= '0;
      cap_op     <= LB;
      cap_lo     <= '0;
      cap_rt     <= '0;
    end else begin
      bus.wp_out <= wp_n;
      if (start_wait) begin
        cap_we    <= bus.mem_wp.we;
        cap_waddr <= bus.mem_wp.waddr;
        cap_op    <= bus.mem_load_op;
        cap_lo    <= bus.mem_addr_lo;
        cap_rt    <= bus.mem_rt_old;
      end
    end
  end
  // a response with no load being taken in IDLE is a memory protocol error
  assert property (@(posedge clk) disable iff (rst)
    idle & bus.dresp_valid |-> accept & bus.mem_is_load);
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors with a queue scoreboard checking every register write
module tb_writeback_stage;
  import writeback_stage_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct packed { regaddr_t waddr; word_t wdata; } exp_t;
  typedef struct packed { load_op_t op; logic [1:0] lo; word_t rdata; word_t rt; word_t exp; } lvec_t;
  exp_t  sb[$];
  lvec_t lv[12];
  writeback_stage_if bus();
  writeback_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input load_op_t op, input logic [1:0] lo,
                       input logic we, input regaddr_t a, input word_t d, input word_t rt,
                       input logic dv, input word_t rd, input logic fl);
    bus.mem_valid   = v;
    bus.mem_is_load = ld;
    bus.mem_load_op = op;
    bus.mem_addr_lo = lo;
    bus.mem_wp      = {we, a, d};
    bus.mem_rt_old  = rt;
    bus.dresp_valid = dv;
    bus.dresp_rdata = rd;
    bus.flush       = fl;
  endtask

  task automatic idle_in;
    drive(1'b0, 1'b0, LW, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.wp_out.we) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got waddr %0d wdata %0h expected no write",
                 bus.wp_out.waddr, bus.wp_out.wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_write", 64'({bus.wp_out.waddr, bus.wp_out.wdata}), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    lv[0]  = {LB,  2'd2, 32'h0080_0000, 32'h0,         32'hFFFF_FF80};
    lv[1]  = {LBU, 2'd2, 32'h0080_0000, 32'h0,         32'h0000_0080};
    lv[2]  = {LH,  2'd2, 32'h8001_0000, 32'h0,         32'hFFFF_8001};
    lv[3]  = {LHU, 2'd0, 32'h1234_F00F, 32'h0,         32'h0000_F00F};
    lv[4]  = {LW,  2'd0, 32'hCAFE_F00D, 32'h0,         32'hCAFE_F00D};
    lv[5]  = {LWL, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hCCDD_3344};
    lv[6]  = {LWR, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h11AA_BBCC};
    lv[7]  = {LWL, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'hDD22_3344};
    lv[8]  = {LWR, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_33AA};
    lv[9]  = {LWL, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD};
    lv[10] = {LWR, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD};
    lv[11] = {LH,  2'd3, 32'h7FFE_0000, 32'h0,         32'h0000_7FFE};
    idle_in();
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    check("rst_wp_out", 64'(bus.wp_out), 64'(0));
    check("rst_ready", 64'(bus.wb_ready), 64'(1));
    // non-load: written one cycle after accept, then we drops
    drive(1'b1, 1'b0, LW, 2'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 1'b0, 32'h0, 1'b0);
    sb.push_back({5'd5, 32'h1234_5678});
    tick;
    idle_in();
    check("alu_wp", 64'(bus.wp_out), 64'({1'b1, 5'd5, 32'h1234_5678}));
    tick;
    check("alu_we_drop", 64'(bus.wp_out.we), 64'(0));
    // back-to-back same-cycle loads
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, lv[i].op, lv[i].lo, 1'b1, 5'(i + 1), 32'h0, lv[i].rt, 1'b1, lv[i].rdata, 1'b0);
      sb.push_back({5'(i + 1), lv[i].exp});
      tick;
      check($sformatf("ld%0d_wdata", i), 64'(bus.wp_out.wdata), 64'(lv[i].exp));
      check($sformatf("ld%0d_ready", i), 64'(bus.wb_ready), 64'(1));
    end
    idle_in();
    tick;
    check("ld_we_drop", 64'(bus.wp_out.we), 64'(0));
    // LW answered three cycles after accept, with a non-load queued behind it
    drive(1'b1, 1'b1, LW, 2'd0, 1'b1, 5'd9, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    sb.push_back({5'd9, 32'hCAFE_BABE});
    sb.push_back({5'd10, 32'h0000_A5A5});
    tick;
    drive(1'b1, 1'b0, LW, 2'd0, 1'b1, 5'd10, 32'h0000_A5A5, 32'h0, 1'b0, 32'h0, 1'b0);
    check("lw_ready_c1", 64'(bus.wb_ready), 64'(0));
    tick;
    check("lw_ready_c2", 64'(bus.wb_ready), 64'(0));
    check("lw_we_c2", 64'(bus.wp_out.we), 64'(0));
    tick;
    check("lw_ready_c3", 64'(bus.wb_ready), 64'(0));
    drive(1'b1, 1'b0, LW, 2'd0, 1'b1, 5'd10, 32'h0000_A5A5, 32'h0, 1'b1, 32'hCAFE_BABE, 1'b0);
    tick;
    drive(1'b1, 1'b0, LW, 2'd0, 1'b1, 5'd10, 32'h0000_A5A5, 32'h0, 1'b0, 32'h0, 1'b0);
    check("lw_wp", 64'(bus.wp_out), 64'({1'b1, 5'd9, 32'hCAFE_BABE}));
    check("lw_ready_c4", 64'(bus.wb_ready), 64'(1));
    tick;
    idle_in();
    check("queued_wp", 64'(bus.wp_out), 64'({1'b1, 5'd10, 32'h0000_A5A5}));
    tick;
    check("queued_we_drop", 64'(bus.wp_out.we), 64'(0));
    // flush in WAIT, response two cycles later is drained without a write
    drive(1'b1, 1'b1, LW, 2'd0, 1'b1, 5'd11, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick;
    drive(1'b0, 1'b0, LW, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("fl_ready_c1", 64'(bus.wb_ready), 64'(0));
    tick;
    idle_in();
    check("fl_state_drain", 64'(dut.state), 64'(WB_DRAIN));
    check("fl_ready_c2", 64'(bus.wb_ready), 64'(0));
    tick;
    drive(1'b0, 1'b0, LW, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
    check("fl_ready_c3", 64'(bus.wb_ready), 64'(0));
    tick;
    idle_in();
    check("fl_ready_back", 64'(bus.wb_ready), 64'(1));
    check("fl_no_write", 64'(bus.wp_out.we), 64'(0));
    // flush together with the response in WAIT
    drive(1'b1, 1'b1, LW, 2'd0, 1'b1, 5'd12, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick;
    drive(1'b0, 1'b0, LW, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 32'h5555_5555, 1'b1);
    tick;
    idle_in();
    check("fl_dv_ready", 64'(bus.wb_ready), 64'(1));
    check("fl_dv_no_write", 64'(bus.wp_out.we), 64'(0));
    // flush in the accept cycle drops the instruction
    drive(1'b1, 1'b0, LW, 2'd0, 1'b1, 5'd13, 32'h77, 32'h0, 1'b0, 32'h0, 1'b1);
    tick;
    idle_in();
    check("fl_acc_no_write", 64'(bus.wp_out.we), 64'(0));
    check("fl_acc_ready", 64'(bus.wb_ready), 64'(1));
    // writes to $0 and loads with we low are suppressed
    drive(1'b1, 1'b0, LW, 2'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 1'b0);
    tick;
    check("r0_alu_we", 64'(bus.wp_out.we), 64'(0));
    drive(1'b1, 1'b1, LW, 2'd0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b1, 32'h1111_2222, 1'b0);
    tick;
    check("r0_load_we", 64'(bus.wp_out.we), 64'(0));
    drive(1'b1, 1'b1, LW, 2'd0, 1'b0, 5'd14, 32'h0, 32'h0, 1'b1, 32'h3333_4444, 1'b0);
    tick;
    idle_in();
    check("we0_load_we", 64'(bus.wp_out.we), 64'(0));
    // reset while a load waits
    drive(1'b1, 1'b0, LW, 2'd0, 1'b1, 5'd3, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 1'b0);
    sb.push_back({5'd3, 32'hFFFF_FFFF});
    tick;
    drive(1'b1, 1'b1, LWL, 2'd2, 1'b1, 5'd4, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    tick;
    idle_in();
    check("rstw_ready_low", 64'(bus.wb_ready), 64'(0));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rstw_wp_out", 64'(bus.wp_out), 64'(0));
    check("rstw_ready", 64'(bus.wb_ready), 64'(1));
    tick;
    tick;
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
